// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Registered execute stage for the 32-bit ALU operation interface. One request
//   is taken per in_valid/in_ready handshake and the result plus flags are
//   presented on an out_valid/out_ready handshake. ADD/SUB/logic ops and
//   zero-distance shifts finish at the accept edge; non-zero shifts run a
//   one-bit-per-cycle serial shifter and finish n cycles after the accept edge.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   request valid
//   in_ready   out  unit can take a request this cycle
//   A, B       in   operands (B[$clog2(WIDTH)-1:0] is the shift distance)
//   mode       in   1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result
//   X          out  result
//   zero       out  X == 0
//   carry      out  ADD carry-out / SUB no-borrow (A >= B unsigned), else 0
//   ovf        out  signed overflow for ADD/SUB, else 0
//   err        out  illegal mode (0 or 9..15)
// -----------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [3:0] MODE_ADD = 4'd1;
  localparam logic [3:0] MODE_SUB = 4'd2;
  localparam logic [3:0] MODE_AND = 4'd3;
  localparam logic [3:0] MODE_OR  = 4'd4;
  localparam logic [3:0] MODE_XOR = 4'd5;
  localparam logic [3:0] MODE_SLL = 4'd6;
  localparam logic [3:0] MODE_SRL = 4'd7;
  localparam logic [3:0] MODE_SRA = 4'd8;

  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0] SUM_ONE  = {{WIDTH{1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       shmode_q, shmode_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             accept;
  logic [SHW-1:0]   shiftAmt;
  logic             isShift;
  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   subSum;
  logic [WIDTH-1:0] immX;
  logic             immCarry;
  logic             immOvf;
  logic             immErr;
  logic [WIDTH-1:0] shifted;

  // One-bit step of the serial shifter; the direction/fill comes from the
  // mode captured at accept, not the live mode input.
  function automatic logic [WIDTH-1:0] shiftOne(input logic [WIDTH-1:0] v,
                                                input logic [3:0]       m);
    case (m)
      MODE_SLL: shiftOne = {v[WIDTH-2:0], 1'b0};
      MODE_SRL: shiftOne = {1'b0, v[WIDTH-1:1]};
      MODE_SRA: shiftOne = {v[WIDTH-1], v[WIDTH-1:1]};
      default:  shiftOne = v;
    endcase
  endfunction

  // Only the IDLE state can accept, and only if the output slot is empty or is
  // being drained in this very cycle.
  assign in_ready = (state_q == ST_IDLE) && (!outValid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign shiftAmt = B[SHW-1:0];
  assign isShift  = (mode == MODE_SLL) || (mode == MODE_SRL) || (mode == MODE_SRA);

  // SUB reuses the adder form A + ~B + 1 so the top bit is directly the
  // no-borrow flag.
  assign addSum  = {1'b0, A} + {1'b0, B};
  assign subSum  = {1'b0, A} + {1'b0, ~B} + SUM_ONE;
  assign shifted = shiftOne(work_q, shmode_q);

  // Single-cycle result for everything that completes at the accept edge,
  // including a shift whose distance is zero (X = A).
  always_comb begin
    immX     = '0;
    immCarry = 1'b0;
    immOvf   = 1'b0;
    immErr   = 1'b0;
    case (mode)
      MODE_ADD: begin
        immX     = addSum[WIDTH-1:0];
        immCarry = addSum[WIDTH];
        immOvf   = (A[WIDTH-1] == B[WIDTH-1]) && (addSum[WIDTH-1] != A[WIDTH-1]);
      end
      MODE_SUB: begin
        immX     = subSum[WIDTH-1:0];
        immCarry = subSum[WIDTH];
        immOvf   = (A[WIDTH-1] != B[WIDTH-1]) && (subSum[WIDTH-1] != A[WIDTH-1]);
      end
      MODE_AND: immX = A & B;
      MODE_OR:  immX = A | B;
      MODE_XOR: immX = A ^ B;
      MODE_SLL, MODE_SRL, MODE_SRA: immX = A;
      default:  immErr = 1'b1;
    endcase
  end

  // Next-state logic. The output registers only change when a new result is
  // produced; otherwise they hold so a stalled consumer sees a stable value.
  // A shift can only finish while out_valid is low because it was accepted
  // into an empty (or draining) slot, so results never overwrite each other.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    shmode_d   = shmode_q;
    outValid_d = outValid_q;
    x_d        = x_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    ovf_d      = ovf_q;
    err_d      = err_q;

    if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (isShift && (shiftAmt != '0)) begin
            work_d   = A;
            cnt_d    = shiftAmt;
            shmode_d = mode;
            state_d  = ST_SHIFT;
          end else begin
            x_d        = immX;
            zero_d     = (immX == '0);
            carry_d    = immCarry;
            ovf_d      = immOvf;
            err_d      = immErr;
            outValid_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          x_d        = shifted;
          zero_d     = (shifted == '0);
          carry_d    = 1'b0;
          ovf_d      = 1'b0;
          err_d      = 1'b0;
          outValid_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any shift in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      cnt_q      <= '0;
      shmode_q   <= '0;
      outValid_q <= 1'b0;
      x_q        <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      shmode_q   <= shmode_d;
      outValid_q <= outValid_d;
      x_q        <= x_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = outValid_q;
  assign X         = x_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

endmodule
